// File: rtl/led_pulse_stretcher_if.sv
// Event-in / LED-out bundle of the pulse stretcher.
// Master drives the event strobe and the overflow clear; slave returns the LED drive and status.
interface led_pulse_stretcher_if #(
    parameter int PEND_W = 4
);
    logic              ev_in;
    logic              clr_ovf;
    logic              outdata;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              ovf;

    modport master (
        output ev_in, clr_ovf,
        input  outdata, busy, pending, ovf
    );

    modport slave (
        input  ev_in, clr_ovf,
        output outdata, busy, pending, ovf
    );
endinterface

// File: rtl/led_pulse_stretcher.sv
// Stretches each ev_in rising edge into one visible blink (ON_CYCLES high, OFF_CYCLES low); outdata rises 1 cycle after the event.
// No backpressure: events arriving mid-blink queue in a saturating counter, and overflow drops them and sets sticky ovf.
module led_pulse_stretcher #(
    parameter int CNT_W      = 26,
    parameter int ON_CYCLES  = 2097152,
    parameter int OFF_CYCLES = 2097152,
    parameter int PEND_W     = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    led_pulse_stretcher_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  timer, timer_nx;
    logic [PEND_W-1:0] pend, pend_nx;
    logic              outdata_r, out_nx;
    logic              busy_r;
    logic              ovf_r, ovf_nx, ovf_set;
    logic              ev_q, ev, enq, timer_done;

    assign ev         = bus.ev_in & ~ev_q;
    assign timer_done = (timer == '0);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        pend_nx  = pend;
        out_nx   = outdata_r;
        enq      = 1'b0;
        ovf_set  = 1'b0;

        case (state)
            IDLE: begin
                if (ev) begin
                    state_nx = ON;
                    timer_nx = ON_LOAD;
                    out_nx   = 1'b1;
                end
            end
            ON: begin
                enq = ev;
                if (timer_done) begin
                    state_nx = GAP;
                    timer_nx = OFF_LOAD;
                    out_nx   = 1'b0;
                end else begin
                    timer_nx = timer - CNT_W'(1);
                end
            end
            GAP: begin
                if (timer_done) begin
                    // An event on the final gap cycle starts the next blink itself, leaving the queue untouched.
                    if (ev || (pend != '0)) begin
                        state_nx = ON;
                        timer_nx = ON_LOAD;
                        out_nx   = 1'b1;
                        if (!ev) begin
                            pend_nx = pend - PEND_W'(1);
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    enq      = ev;
                    timer_nx = timer - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
                out_nx   = 1'b0;
            end
        endcase

        if (enq) begin
            if (pend == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_nx = pend + PEND_W'(1);
            end
        end

        ovf_nx = ovf_set | (ovf_r & ~bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            pend      <= '0;
            outdata_r <= 1'b0;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
            ev_q      <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            pend      <= pend_nx;
            outdata_r <= out_nx;
            busy_r    <= (state_nx != IDLE);
            ovf_r     <= ovf_nx;
            ev_q      <= bus.ev_in;
        end
    end

    assign bus.outdata = outdata_r;
    assign bus.busy    = busy_r;
    assign bus.pending = pend;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher: blink-schedule model compared every cycle, plus literal pins on directed scenarios.
module tb_led_pulse_stretcher;
    localparam int CNT_W  = 4;
    localparam int ON_C   = 3;
    localparam int OFF_C  = 2;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic clk;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    led_pulse_stretcher_if #(.PEND_W(PEND_W)) bus ();

    led_pulse_stretcher #(
        .CNT_W(CNT_W), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_W(PEND_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: every accepted event owns a blink slot [start, start+ON+OFF); slots are laid end to end.
    int  n = 0;
    int  starts[$];
    int  tail = 0;
    bit  m_evq = 0;
    bit  m_ovf = 0;

    always begin
        int cnt;
        bit ev, drop, e_out, e_busy;
        int e_pend;
        @(posedge clk);
        if (!rstn) begin
            starts.delete();
            tail  = 0;
            m_evq = 0;
            m_ovf = 0;
        end else begin
            ev    = bus.ev_in && !m_evq;
            m_evq = bus.ev_in;
            drop  = 0;
            if (ev) begin
                if (tail <= n) begin
                    starts.push_back(n);
                    tail = n + ON_C + OFF_C;
                end else begin
                    cnt = 0;
                    foreach (starts[i]) if (starts[i] > n) cnt++;
                    if (cnt == PMAX) begin
                        drop = 1;
                    end else begin
                        starts.push_back(tail);
                        tail = tail + ON_C + OFF_C;
                    end
                end
            end
            if (drop) m_ovf = 1;
            else if (bus.clr_ovf) m_ovf = 0;
            while (starts.size() > 0 && starts[0] + ON_C + OFF_C <= n) void'(starts.pop_front());
        end
        e_out = 0; e_busy = 0; e_pend = 0;
        foreach (starts[i]) begin
            if (starts[i] <= n && n < starts[i] + ON_C) e_out = 1;
            if (starts[i] <= n && n < starts[i] + ON_C + OFF_C) e_busy = 1;
            if (starts[i] > n) e_pend++;
        end
        #1;
        chk("model_outdata", int'(bus.outdata), int'(e_out));
        chk("model_busy", int'(bus.busy), int'(e_busy));
        chk("model_pending", int'(bus.pending), e_pend);
        chk("model_ovf", int'(bus.ovf), int'(m_ovf));
        n++;
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulses(input int count);
        for (int i = 0; i < count; i++) begin
            bus.ev_in = 1'b1;
            @(negedge clk);
            if (i != count - 1) begin
                bus.ev_in = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rstn        = 1'b0;
        bus.ev_in   = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outdata", int'(bus.outdata), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_pending", int'(bus.pending), 0);
        chk("reset_ovf", int'(bus.ovf), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single event: 3 high, 2 low, then idle.
        bus.ev_in = 1'b1;
        @(negedge clk);
        bus.ev_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("single_out_k%0d", k), int'(bus.outdata), (k < 3) ? 1 : 0);
            chk($sformatf("single_busy_k%0d", k), int'(bus.busy), (k < 5) ? 1 : 0);
            chk($sformatf("single_pend_k%0d", k), int'(bus.pending), 0);
            @(negedge clk);
        end
        wait_idle();

        // Held level: one blink only.
        bus.ev_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_busy", int'(bus.busy), 0);
        chk("held_pending", int'(bus.pending), 0);
        bus.ev_in = 1'b0;
        wait_idle();

        // Three queued events behind the first.
        pulses(4);
        bus.ev_in = 1'b0;
        wait_idle();

        // Overflow, clear, and set-beats-clear.
        pulses(7);
        chk("ovf_pending_full", int'(bus.pending), PMAX);
        chk("ovf_set", int'(bus.ovf), 1);
        bus.ev_in   = 1'b0;
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        chk("ovf_cleared", int'(bus.ovf), 0);
        bus.ev_in = 1'b1;
        @(negedge clk);
        bus.ev_in   = 1'b0;
        bus.clr_ovf = 1'b0;
        chk("ovf_set_wins", int'(bus.ovf), 1);
        chk("ovf_pending_hold", int'(bus.pending), PMAX);
        wait_idle();

        // Event on the final gap cycle chains straight into the next blink.
        bus.ev_in = 1'b1;
        @(negedge clk);
        bus.ev_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("chain_gap_low", int'(bus.outdata), 0);
        chk("chain_gap_busy", int'(bus.busy), 1);
        bus.ev_in = 1'b1;
        @(negedge clk);
        bus.ev_in = 1'b0;
        chk("chain_restart", int'(bus.outdata), 1);
        chk("chain_pending", int'(bus.pending), 0);
        wait_idle();

        // Asynchronous reset mid-blink with a queue.
        pulses(4);
        bus.ev_in = 1'b0;
        chk("arst_pre_pending", int'(bus.pending), 2);
        chk("arst_pre_out", int'(bus.outdata), 1);
        rstn = 1'b0;
        #1;
        chk("arst_outdata", int'(bus.outdata), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_pending", int'(bus.pending), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_stays_idle", int'(bus.busy), 0);

        // Randomised traffic with varying event density, clears and occasional resets.
        for (int seg = 0; seg < 15; seg++) begin
            int dens;
            dens = $urandom_range(5, 80);
            for (int c = 0; c < 200; c++) begin
                bus.ev_in   = ($urandom_range(0, 99) < dens);
                bus.clr_ovf = ($urandom_range(0, 19) == 0);
                rstn        = ($urandom_range(0, 399) != 0);
                @(negedge clk);
            end
        end
        rstn        = 1'b1;
        bus.ev_in   = 1'b0;
        bus.clr_ovf = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
